// File: rtl/join_sequencer_if.sv
// Join sequencer types and port bundle.
// Shared flit format plus the handshake interface.
package join_sequencer_pkg;

  typedef logic [7:0] node_id_t;

  localparam node_id_t BROADCAST_ID = 8'hFF;

  typedef enum logic [1:0] {
    HEAD   = 2'd0,
    BODY   = 2'd1,
    TAIL   = 2'd2,
    SYSTEM = 2'd3
  } flit_type_e;

  typedef enum logic [2:0] {
    S_NONE                         = 3'd0,
    S_PARENT_REQUEST_FROM_NEIGHBOR = 3'd1,
    S_PARENT_ACK_FROM_NEIGHBOR     = 3'd2,
    S_JOIN_REQUEST                 = 3'd3,
    S_JOIN_ACK                     = 3'd4
  } sys_header_e;

  typedef struct packed {
    flit_type_e flittype;
    node_id_t   src_id;
    node_id_t   dst_id;
  } flit_hdr_t;

  typedef struct packed {
    node_id_t parent_id;
    node_id_t random_child_id;
  } join_req_t;

  typedef struct packed {
    node_id_t parent_id;
    node_id_t random_child_id;
    node_id_t child_id;
  } join_ack_t;

  typedef struct packed {
    sys_header_e header;
    join_req_t   join_request;
    join_ack_t   join_ack;
  } sys_body_t;

  typedef struct packed {
    flit_hdr_t header;
    sys_body_t system;
  } flit_t;

endpackage

interface join_sequencer_if;
  import join_sequencer_pkg::*;

  logic     start;
  logic     is_root;
  node_id_t random_id;
  logic     flit_out_valid;
  logic     flit_out_ready;
  flit_t    flit_out;
  logic     flit_in_valid;
  flit_t    flit_in;
  node_id_t temporal_id;
  logic     parent_valid;
  node_id_t parent_node_id;
  logic     this_node_valid;
  node_id_t this_node_id;
  logic     busy;
  logic     join_failed;

  modport master (
    input  start, is_root, random_id,
    input  flit_out_ready,
    input  flit_in_valid, flit_in,
    output flit_out_valid, flit_out,
    output temporal_id,
    output parent_valid, parent_node_id,
    output this_node_valid, this_node_id,
    output busy, join_failed
  );

  modport slave (
    output start, is_root, random_id,
    output flit_out_ready,
    output flit_in_valid, flit_in,
    input  flit_out_valid, flit_out,
    input  temporal_id,
    input  parent_valid, parent_node_id,
    input  this_node_valid, this_node_id,
    input  busy, join_failed
  );

endinterface

// File: rtl/join_sequencer.sv
// Non-root join initiator: parent request, join
// request, timeout/retry/backoff, id adoption.
module join_sequencer
  import join_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BACKOFF_CYCLES = 64,
  parameter int MAX_RETRY      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  join_sequencer_if.master   io
);

  localparam int TMAX =
    (TIMEOUT_CYCLES > BACKOFF_CYCLES) ?
    TIMEOUT_CYCLES : BACKOFF_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    IDLE, SEND_PREQ, WAIT_PACK, SEND_JREQ,
    WAIT_JACK, BACKOFF, JOINED, FAILED
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retry_q, retry_d;
  node_id_t        temp_q, temp_d;
  node_id_t        par_q, par_d;
  logic            par_v_q, par_v_d;
  node_id_t        node_q, node_d;
  logic            node_v_q, node_v_d;
  logic            fail_q, fail_d;

  logic            is_sys;
  logic            pack_hit;
  logic            jack_hit;
  logic            tmo;
  logic [RW-1:0]   retry_inc;
  logic            unused_jreq;

  assign unused_jreq = ^io.flit_in.system.join_request;

  assign is_sys = io.flit_in_valid &&
    (io.flit_in.header.flittype == SYSTEM);

  assign pack_hit = is_sys &&
    (io.flit_in.system.header ==
     S_PARENT_ACK_FROM_NEIGHBOR) &&
    (io.flit_in.header.dst_id == temp_q);

  assign jack_hit = is_sys &&
    (io.flit_in.system.header == S_JOIN_ACK) &&
    (io.flit_in.system.join_ack.random_child_id
     == temp_q) &&
    (io.flit_in.system.join_ack.parent_id
     == par_q);

  assign tmo = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign retry_inc = retry_q + RW'(1);

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      retry_q  <= '0;
      temp_q   <= '0;
      par_q    <= '0;
      par_v_q  <= 1'b0;
      node_q   <= '0;
      node_v_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      temp_q   <= temp_d;
      par_q    <= par_d;
      par_v_q  <= par_v_d;
      node_q   <= node_d;
      node_v_q <= node_v_d;
      fail_q   <= fail_d;
    end
  end

  // next-state: handshake progress, matching, timeout
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    temp_d   = temp_q;
    par_d    = par_q;
    par_v_d  = par_v_q;
    node_d   = node_q;
    node_v_d = node_v_q;
    fail_d   = fail_q;
    unique case (state_q)
      IDLE, FAILED: begin
        if (io.start && io.is_root) begin
          state_d  = JOINED;
          node_d   = '0;
          node_v_d = 1'b1;
          par_v_d  = 1'b0;
          fail_d   = 1'b0;
        end else if (io.start) begin
          state_d = SEND_PREQ;
          temp_d  = io.random_id;
          retry_d = '0;
          fail_d  = 1'b0;
          timer_d = '0;
        end
      end
      SEND_PREQ, SEND_JREQ: begin
        if (io.flit_out_ready) begin
          state_d = (state_q == SEND_PREQ) ?
                    WAIT_PACK : WAIT_JACK;
          timer_d = '0;
        end
      end
      WAIT_PACK, WAIT_JACK: begin
        if (state_q == WAIT_PACK && pack_hit) begin
          state_d = SEND_JREQ;
          par_d   = io.flit_in.header.src_id;
          par_v_d = 1'b1;
        end else if (state_q == WAIT_JACK &&
                     jack_hit) begin
          state_d  = JOINED;
          node_d   = io.flit_in.system.join_ack.child_id;
          node_v_d = 1'b1;
        end else if (tmo) begin
          par_v_d = 1'b0;
          retry_d = retry_inc;
          timer_d = '0;
          if (retry_inc == RW'(MAX_RETRY)) begin
            state_d = FAILED;
            fail_d  = 1'b1;
          end else begin
            state_d = BACKOFF;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      BACKOFF: begin
        if (timer_q == TW'(BACKOFF_CYCLES - 1)) begin
          state_d = SEND_PREQ;
          temp_d  = io.random_id;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      JOINED: begin
        state_d = JOINED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // outgoing flit formed from state and held registers
  always_comb begin
    io.flit_out       = '0;
    io.flit_out_valid = 1'b0;
    unique case (1'b1)
      (state_q == SEND_PREQ): begin
        io.flit_out_valid            = 1'b1;
        io.flit_out.header.flittype  = SYSTEM;
        io.flit_out.header.src_id    = temp_q;
        io.flit_out.header.dst_id    = BROADCAST_ID;
        io.flit_out.system.header    =
          S_PARENT_REQUEST_FROM_NEIGHBOR;
      end
      (state_q == SEND_JREQ): begin
        io.flit_out_valid            = 1'b1;
        io.flit_out.header.flittype  = SYSTEM;
        io.flit_out.header.src_id    = temp_q;
        io.flit_out.header.dst_id    = par_q;
        io.flit_out.system.header    = S_JOIN_REQUEST;
        io.flit_out.system.join_request.parent_id =
          par_q;
        io.flit_out.system.join_request
          .random_child_id = temp_q;
      end
      default: begin
        io.flit_out_valid = 1'b0;
      end
    endcase
  end

  assign io.temporal_id     = temp_q;
  assign io.parent_valid    = par_v_q;
  assign io.parent_node_id  = par_q;
  assign io.this_node_valid = node_v_q;
  assign io.this_node_id    = node_q;
  assign io.join_failed     = fail_q;
  assign io.busy = !(state_q == IDLE ||
                     state_q == JOINED ||
                     state_q == FAILED);

endmodule

// File: tb/tb_join_sequencer.sv
// Directed bench for join_sequencer.
// Short timeout/backoff keep retry runs brief.
module tb_join_sequencer;
  import join_sequencer_pkg::*;

  localparam int T = 32;
  localparam int B = 8;
  localparam int R = 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  join_sequencer_if ifc ();

  join_sequencer #(
    .TIMEOUT_CYCLES (T),
    .BACKOFF_CYCLES (B),
    .MAX_RETRY      (R)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic flit_t mk_preq(node_id_t s);
    flit_t f;
    f = '0;
    f.header.flittype = SYSTEM;
    f.header.src_id   = s;
    f.header.dst_id   = BROADCAST_ID;
    f.system.header   = S_PARENT_REQUEST_FROM_NEIGHBOR;
    return f;
  endfunction

  function automatic flit_t mk_jreq(node_id_t s,
                                    node_id_t p);
    flit_t f;
    f = '0;
    f.header.flittype = SYSTEM;
    f.header.src_id   = s;
    f.header.dst_id   = p;
    f.system.header   = S_JOIN_REQUEST;
    f.system.join_request.parent_id       = p;
    f.system.join_request.random_child_id = s;
    return f;
  endfunction

  function automatic flit_t mk_pack(node_id_t s,
                                    node_id_t d);
    flit_t f;
    f = '0;
    f.header.flittype = SYSTEM;
    f.header.src_id   = s;
    f.header.dst_id   = d;
    f.system.header   = S_PARENT_ACK_FROM_NEIGHBOR;
    return f;
  endfunction

  function automatic flit_t mk_jack(node_id_t p,
                                    node_id_t r,
                                    node_id_t c);
    flit_t f;
    f = '0;
    f.header.flittype = SYSTEM;
    f.header.src_id   = p;
    f.header.dst_id   = BROADCAST_ID;
    f.system.header   = S_JOIN_ACK;
    f.system.join_ack.parent_id       = p;
    f.system.join_ack.random_child_id = r;
    f.system.join_ack.child_id        = c;
    return f;
  endfunction

  task automatic rx(input flit_t f);
    ifc.flit_in       = f;
    ifc.flit_in_valid = 1'b1;
    tick();
    ifc.flit_in_valid = 1'b0;
    ifc.flit_in       = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int cyc;
    int last;
    int n;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    ifc.start          = 1'b0;
    ifc.is_root        = 1'b0;
    ifc.random_id      = '0;
    ifc.flit_out_ready = 1'b0;
    ifc.flit_in_valid  = 1'b0;
    ifc.flit_in        = '0;

    // 1: reset state, then broadcast PREQ
    do_reset();
    chk("rst_valid", 64'(ifc.flit_out_valid), 0);
    chk("rst_flit", 64'(ifc.flit_out), 0);
    chk("rst_busy", 64'(ifc.busy), 0);
    chk("rst_nodev", 64'(ifc.this_node_valid), 0);
    chk("rst_fail", 64'(ifc.join_failed), 0);
    ifc.random_id      = 8'h2A;
    ifc.flit_out_ready = 1'b1;
    ifc.start          = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("preq_valid", 64'(ifc.flit_out_valid), 1);
    chk("preq_flit", 64'(ifc.flit_out),
        64'(mk_preq(8'h2A)));
    chk("preq_busy", 64'(ifc.busy), 1);
    chk("temporal", 64'(ifc.temporal_id), 64'h2A);
    tick();
    chk("wpack_valid", 64'(ifc.flit_out_valid), 0);

    // 2: PACK, JREQ, duplicate PACK, JACK
    rx(mk_pack(8'h05, 8'h2A));
    chk("par_v", 64'(ifc.parent_valid), 1);
    chk("par_id", 64'(ifc.parent_node_id), 5);
    chk("jreq_valid", 64'(ifc.flit_out_valid), 1);
    chk("jreq_flit", 64'(ifc.flit_out),
        64'(mk_jreq(8'h2A, 8'h05)));
    tick();
    rx(mk_pack(8'h07, 8'h2A));
    chk("dup_pack", 64'(ifc.parent_node_id), 5);
    rx(mk_jack(8'h06, 8'h2A, 8'h09));
    chk("bad_jack", 64'(ifc.this_node_valid), 0);
    rx(mk_jack(8'h05, 8'h2A, 8'h09));
    chk("join_v", 64'(ifc.this_node_valid), 1);
    chk("join_id", 64'(ifc.this_node_id), 9);
    chk("join_busy", 64'(ifc.busy), 0);
    ifc.random_id = 8'h77;
    ifc.start     = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("joined_start", 64'(ifc.flit_out_valid), 0);
    chk("joined_temp", 64'(ifc.temporal_id), 64'h2A);

    // 3: backpressure and filtering
    do_reset();
    ifc.random_id      = 8'h31;
    ifc.flit_out_ready = 1'b0;
    ifc.start          = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("hold_v", 64'(ifc.flit_out_valid), 1);
      chk("hold_f", 64'(ifc.flit_out),
          64'(mk_preq(8'h31)));
      tick();
    end
    ifc.flit_out_ready = 1'b1;
    tick();
    rx(mk_pack(8'h05, 8'h2B));
    chk("pack_dst", 64'(ifc.parent_valid), 0);
    chk("pack_dst_v", 64'(ifc.flit_out_valid), 0);
    rx(mk_pack(8'h05, 8'h31));
    chk("pack_ok", 64'(ifc.parent_node_id), 5);
    rx(mk_pack(8'h07, 8'h31));
    chk("pack_2nd", 64'(ifc.parent_node_id), 5);

    // 4: no acks -> retries, then failure
    do_reset();
    ifc.random_id = 8'h40;
    ifc.start     = 1'b1;
    tick();
    ifc.start = 1'b0;
    cyc  = 0;
    last = 0;
    n    = 0;
    while (!ifc.join_failed && cyc < 400) begin
      if (ifc.flit_out_valid) begin
        chk("retry_flit", 64'(ifc.flit_out),
            64'(mk_preq(8'(8'h40 + n))));
        if (n > 0)
          chk("retry_gap", 64'(cyc - last),
              64'(T + B + 1));
        last = cyc;
        n++;
        ifc.random_id = 8'(8'h40 + n);
      end
      tick();
      cyc++;
    end
    chk("retry_cnt", 64'(n), 64'(R));
    chk("fail_time", 64'(cyc - last), 64'(T + 1));
    chk("fail_flag", 64'(ifc.join_failed), 1);
    chk("fail_busy", 64'(ifc.busy), 0);
    chk("fail_parv", 64'(ifc.parent_valid), 0);
    ifc.random_id = 8'h50;
    ifc.start     = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("restart_f", 64'(ifc.flit_out),
        64'(mk_preq(8'h50)));
    chk("restart_fail", 64'(ifc.join_failed), 0);

    // 5: JACK on the timeout cycle wins
    tick();
    rx(mk_pack(8'h03, 8'h50));
    tick();
    for (int i = 0; i < T - 1; i++) tick();
    chk("edge_busy", 64'(ifc.busy), 1);
    rx(mk_jack(8'h03, 8'h50, 8'h11));
    chk("edge_join", 64'(ifc.this_node_valid), 1);
    chk("edge_id", 64'(ifc.this_node_id), 64'h11);
    chk("edge_fail", 64'(ifc.join_failed), 0);
    chk("edge_parv", 64'(ifc.parent_valid), 1);

    do_reset();
    ifc.is_root = 1'b1;
    ifc.start   = 1'b1;
    tick();
    ifc.start   = 1'b0;
    chk("root_v", 64'(ifc.this_node_valid), 1);
    chk("root_id", 64'(ifc.this_node_id), 0);
    chk("root_flit", 64'(ifc.flit_out_valid), 0);
    chk("root_busy", 64'(ifc.busy), 0);
    chk("root_parv", 64'(ifc.parent_valid), 0);

    // 6: async reset mid-handshake
    do_reset();
    ifc.is_root   = 1'b0;
    ifc.random_id = 8'h2A;
    ifc.start     = 1'b1;
    tick();
    ifc.start = 1'b0;
    tick();
    rx(mk_pack(8'h05, 8'h2A));
    tick();
    chk("wjack_busy", 64'(ifc.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ifc.flit_out_valid), 0);
    chk("arst_parv", 64'(ifc.parent_valid), 0);
    chk("arst_temp", 64'(ifc.temporal_id), 0);
    chk("arst_busy", 64'(ifc.busy), 0);
    #12;
    rst_n = 1'b1;
    tick();
    ifc.flit_out_ready = 1'b0;
    ifc.start          = 1'b1;
    tick();
    ifc.start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_preq", 64'(ifc.flit_out_valid), 0);
    #12;
    rst_n = 1'b1;
    tick();
    ifc.flit_out_ready = 1'b1;
    ifc.start          = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("again_flit", 64'(ifc.flit_out),
        64'(mk_preq(8'h2A)));
    chk("again_busy", 64'(ifc.busy), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
